// File: rtl/native_aip.sv
// native_aip: CPU-side native bus bridge to an AIP core.
// Register map (addr[3:2]): 0 DATA, 1 CONFIG, 2 START, 3 STATUS.
// Each request runs IDLE -> ACCESS -> ACK, with ready asserted in ACK.
// Optional feature: define NATIVE_AIP_IRQ_EN to build the sticky interrupt
// logic and the writable STATUS register. Without it the interrupt outputs
// are tied low and STATUS only reports the live AIP interrupt level.
module native_aip (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_cpu_mem_valid,
   input  logic [31:0] i_cpu_mem_addr,
   input  logic [31:0] i_cpu_mem_wdata,
   input  logic        i_cpu_mem_wen,
   output logic [31:0] o_cpu_mem_rdata,
   output logic        o_cpu_mem_ready,
   output logic        o_cpu_irq,
   output logic        o_core_int,
   input  logic        i_aip_sel,
   input  logic        i_aip_enable,
   input  logic [31:0] i_aip_dataOut,
   input  logic        i_aip_int,
   output logic [31:0] o_aip_dataIn,
   output logic [4:0]  o_aip_config,
   output logic        o_aip_read,
   output logic        o_aip_write,
   output logic        o_aip_start
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_CONFIG = 2'd1;
   localparam logic [1:0] REG_START  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   state_t      state_q, state_d;
   logic [1:0]  reg_sel_q, reg_sel_d;
   logic [4:0]  wdata_q, wdata_d;
   logic        wen_q, wen_d;
   logic        en_q, en_d;
   logic [31:0] data_in_q, data_in_d;
   logic [4:0]  config_q, config_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic        start_q, start_d;
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;

`ifdef NATIVE_AIP_IRQ_EN
   logic        int_pending_q, int_pending_d;
   logic        irq_en_q, irq_en_d;
   logic        int_prev_q, int_prev_d;
   logic        irq_q, irq_d;
   logic        status_wr;
`endif

   // Only address bits [3:2] select a register; the rest are don't-care.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_cpu_mem_addr[31:4], i_cpu_mem_addr[1:0]};

   // Next-state, strobe, register-update and read-data logic.
   always_comb begin
      state_d   = state_q;
      reg_sel_d = reg_sel_q;
      wdata_d   = wdata_q;
      wen_d     = wen_q;
      en_d      = en_q;
      data_in_d = data_in_q;
      config_d  = config_q;
      read_d    = 1'b0;
      write_d   = 1'b0;
      start_d   = 1'b0;
      ready_d   = 1'b0;
      rdata_d   = 32'd0;

      case (state_q)
         ST_IDLE: begin
            if (i_cpu_mem_valid && i_aip_sel) begin
               state_d   = ST_ACCESS;
               reg_sel_d = i_cpu_mem_addr[3:2];
               wdata_d   = i_cpu_mem_wdata[4:0];
               wen_d     = i_cpu_mem_wen;
               en_d      = i_aip_enable;
               // Strobes are registered here so they are high exactly
               // during ACCESS; DATA is loaded now so it is valid with write.
               if (i_aip_enable) begin
                  case (i_cpu_mem_addr[3:2])
                     REG_DATA: begin
                        if (i_cpu_mem_wen) begin
                           data_in_d = i_cpu_mem_wdata;
                           write_d   = 1'b1;
                        end else begin
                           read_d = 1'b1;
                        end
                     end
                     REG_START: begin
                        if (i_cpu_mem_wen && i_cpu_mem_wdata[0]) begin
                           start_d = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_ACCESS: begin
            state_d = ST_ACK;
            ready_d = 1'b1;
            if (en_q && !wen_q) begin
               case (reg_sel_q)
                  REG_DATA:   rdata_d = i_aip_dataOut;
                  REG_CONFIG: rdata_d = {27'd0, config_q};
`ifdef NATIVE_AIP_IRQ_EN
                  REG_STATUS: rdata_d = {29'd0, i_aip_int, irq_en_q, int_pending_q};
`else
                  REG_STATUS: rdata_d = {29'd0, i_aip_int, 2'b00};
`endif
                  default:    rdata_d = 32'd0;
               endcase
            end
            if (en_q && wen_q && (reg_sel_q == REG_CONFIG)) begin
               config_d = wdata_q;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef NATIVE_AIP_IRQ_EN
   // Sticky interrupt: set on a rising AIP interrupt, cleared by a STATUS
   // write with bit0 set; a simultaneous set wins over the clear.
   always_comb begin
      status_wr     = (state_q == ST_ACCESS) && en_q && wen_q && (reg_sel_q == REG_STATUS);
      int_prev_d    = i_aip_int;
      int_pending_d = int_pending_q;
      irq_en_d      = irq_en_q;
      if (status_wr) begin
         irq_en_d = wdata_q[1];
         if (wdata_q[0]) begin
            int_pending_d = 1'b0;
         end
      end
      if (i_aip_int && !int_prev_q) begin
         int_pending_d = 1'b1;
      end
      irq_d = int_pending_d && irq_en_d;
   end
`endif

   // State and register storage; reset aborts any transaction in progress.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q       <= ST_IDLE;
         reg_sel_q     <= 2'd0;
         wdata_q       <= 5'd0;
         wen_q         <= 1'b0;
         en_q          <= 1'b0;
         data_in_q     <= 32'd0;
         config_q      <= 5'd0;
         read_q        <= 1'b0;
         write_q       <= 1'b0;
         start_q       <= 1'b0;
         ready_q       <= 1'b0;
         rdata_q       <= 32'd0;
`ifdef NATIVE_AIP_IRQ_EN
         int_pending_q <= 1'b0;
         irq_en_q      <= 1'b0;
         int_prev_q    <= 1'b0;
         irq_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         reg_sel_q     <= reg_sel_d;
         wdata_q       <= wdata_d;
         wen_q         <= wen_d;
         en_q          <= en_d;
         data_in_q     <= data_in_d;
         config_q      <= config_d;
         read_q        <= read_d;
         write_q       <= write_d;
         start_q       <= start_d;
         ready_q       <= ready_d;
         rdata_q       <= rdata_d;
`ifdef NATIVE_AIP_IRQ_EN
         int_pending_q <= int_pending_d;
         irq_en_q      <= irq_en_d;
         int_prev_q    <= int_prev_d;
         irq_q         <= irq_d;
`endif
      end
   end

   assign o_cpu_mem_rdata = rdata_q;
   assign o_cpu_mem_ready = ready_q;
   assign o_aip_dataIn    = data_in_q;
   assign o_aip_config    = config_q;
   assign o_aip_read      = read_q;
   assign o_aip_write     = write_q;
   assign o_aip_start     = start_q;
`ifdef NATIVE_AIP_IRQ_EN
   assign o_cpu_irq       = irq_q;
   assign o_core_int      = irq_q;
`else
   assign o_cpu_irq       = 1'b0;
   assign o_core_int      = 1'b0;
`endif

endmodule

// File: tb/tb_native_aip.sv
// Self-checking bench for native_aip: directed register scenarios followed by
// randomized transactions, compared against a register-level behavioural model.
module tb_native_aip;

   localparam logic [1:0] R_DATA   = 2'd0;
   localparam logic [1:0] R_CONFIG = 2'd1;
   localparam logic [1:0] R_START  = 2'd2;
   localparam logic [1:0] R_STATUS = 2'd3;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_cpu_mem_valid;
   logic [31:0] i_cpu_mem_addr;
   logic [31:0] i_cpu_mem_wdata;
   logic        i_cpu_mem_wen;
   logic [31:0] o_cpu_mem_rdata;
   logic        o_cpu_mem_ready;
   logic        o_cpu_irq;
   logic        o_core_int;
   logic        i_aip_sel;
   logic        i_aip_enable;
   logic [31:0] i_aip_dataOut;
   logic        i_aip_int;
   logic [31:0] o_aip_dataIn;
   logic [4:0]  o_aip_config;
   logic        o_aip_read;
   logic        o_aip_write;
   logic        o_aip_start;

   // Reference model state: the programmer-visible registers.
   logic [4:0]  mConfig;
   logic [31:0] mDataIn;
   logic        mPending;
   logic        mIrqEn;
   logic        mIntPrev;

   int checkCount = 0;
   int passCount  = 0;

   native_aip dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_cpu_mem_valid (i_cpu_mem_valid),
      .i_cpu_mem_addr  (i_cpu_mem_addr),
      .i_cpu_mem_wdata (i_cpu_mem_wdata),
      .i_cpu_mem_wen   (i_cpu_mem_wen),
      .o_cpu_mem_rdata (o_cpu_mem_rdata),
      .o_cpu_mem_ready (o_cpu_mem_ready),
      .o_cpu_irq       (o_cpu_irq),
      .o_core_int      (o_core_int),
      .i_aip_sel       (i_aip_sel),
      .i_aip_enable    (i_aip_enable),
      .i_aip_dataOut   (i_aip_dataOut),
      .i_aip_int       (i_aip_int),
      .o_aip_dataIn    (o_aip_dataIn),
      .o_aip_config    (o_aip_config),
      .o_aip_read      (o_aip_read),
      .o_aip_write     (o_aip_write),
      .o_aip_start     (o_aip_start)
   );

   // Free-running 100 MHz clock.
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
      end else begin
         passCount++;
      end
   endtask

   function automatic logic expIrq();
`ifdef NATIVE_AIP_IRQ_EN
      return mPending && mIrqEn;
`else
      return 1'b0;
`endif
   endfunction

   // Model of the interrupt bookkeeping at one rising clock edge.
   task automatic modelEdge(input logic clearReq);
      logic rising;
      rising   = i_aip_int && !mIntPrev;
      mIntPrev = i_aip_int;
      if (clearReq) mPending = 1'b0;
      if (rising) mPending = 1'b1;
   endtask

   task automatic modelReset();
      mConfig  = 5'd0;
      mDataIn  = 32'd0;
      mPending = 1'b0;
      mIrqEn   = 1'b0;
      mIntPrev = 1'b0;
   endtask

   task automatic checkStatic(input string tag);
      checkOutput({tag, ".dataIn"}, o_aip_dataIn, mDataIn);
      checkOutput({tag, ".config"}, {27'd0, o_aip_config}, {27'd0, mConfig});
      checkOutput({tag, ".irq"}, {30'd0, o_cpu_irq, o_core_int}, {30'd0, expIrq(), expIrq()});
   endtask

   // One idle cycle; the request is never routed here, so nothing may start.
   task automatic idleCycle(input logic intVal);
      @(negedge i_clk);
      i_cpu_mem_valid = 1'($urandom);
      i_aip_sel       = 1'b0;
      i_aip_int       = intVal;
      @(posedge i_clk);
      modelEdge(1'b0);
      #1;
      checkOutput("idle.ready", {31'd0, o_cpu_mem_ready}, 32'd0);
      checkOutput("idle.strobes", {29'd0, o_aip_read, o_aip_write, o_aip_start}, 32'd0);
      checkOutput("idle.irq", {31'd0, o_cpu_irq}, {31'd0, expIrq()});
   endtask

   // One full bus transaction, checked through ACCESS, ACK and return to IDLE.
   task automatic applyStimulus(input logic [1:0] regIdx, input logic [31:0] wdataIn, input logic wen,
                                input logic enable, input logic [31:0] aipData, input logic intDuring);
      logic [31:0] junk;
      logic [31:0] expRdata;
      logic        clearReq;
      junk = $urandom;
      @(negedge i_clk);
      i_cpu_mem_valid = 1'b1;
      i_aip_sel       = 1'b1;
      i_cpu_mem_addr  = {junk[31:4], regIdx, junk[1:0]};
      i_cpu_mem_wdata = wdataIn;
      i_cpu_mem_wen   = wen;
      i_aip_enable    = enable;
      @(posedge i_clk);
      modelEdge(1'b0);
      if (enable && wen && regIdx == R_DATA) mDataIn = wdataIn;
      @(negedge i_clk);
      // Scramble the request inputs; the captured transaction must not change.
      i_cpu_mem_valid = 1'($urandom);
      i_aip_sel       = 1'($urandom);
      i_cpu_mem_addr  = $urandom;
      i_cpu_mem_wdata = $urandom;
      i_cpu_mem_wen   = 1'($urandom);
      i_aip_int       = intDuring;
      i_aip_dataOut   = aipData;
      checkOutput("access.ready", {31'd0, o_cpu_mem_ready}, 32'd0);
      checkOutput("access.rdata", o_cpu_mem_rdata, 32'd0);
      checkOutput("access.read", {31'd0, o_aip_read}, {31'd0, enable && !wen && regIdx == R_DATA});
      checkOutput("access.write", {31'd0, o_aip_write}, {31'd0, enable && wen && regIdx == R_DATA});
      checkOutput("access.start", {31'd0, o_aip_start}, {31'd0, enable && wen && regIdx == R_START && wdataIn[0]});
      checkStatic("access");
      expRdata = 32'd0;
      if (enable && !wen) begin
         case (regIdx)
            R_DATA:   expRdata = aipData;
            R_CONFIG: expRdata = 32'(mConfig);
`ifdef NATIVE_AIP_IRQ_EN
            R_STATUS: expRdata = 32'({intDuring, mIrqEn, mPending});
`else
            R_STATUS: expRdata = 32'({intDuring, 2'b00});
`endif
            default:  expRdata = 32'd0;
         endcase
      end
      @(posedge i_clk);
      clearReq = 1'b0;
      if (enable && wen && regIdx == R_CONFIG) mConfig = wdataIn[4:0];
`ifdef NATIVE_AIP_IRQ_EN
      if (enable && wen && regIdx == R_STATUS) begin
         mIrqEn   = wdataIn[1];
         clearReq = wdataIn[0];
      end
`endif
      modelEdge(clearReq);
      @(negedge i_clk);
      i_cpu_mem_valid = 1'b0;
      i_aip_dataOut   = $urandom;
      checkOutput("ack.ready", {31'd0, o_cpu_mem_ready}, 32'd1);
      checkOutput("ack.rdata", o_cpu_mem_rdata, expRdata);
      checkOutput("ack.strobes", {29'd0, o_aip_read, o_aip_write, o_aip_start}, 32'd0);
      checkStatic("ack");
      @(posedge i_clk);
      modelEdge(1'b0);
      @(negedge i_clk);
      checkOutput("done.ready", {31'd0, o_cpu_mem_ready}, 32'd0);
      checkOutput("done.rdata", o_cpu_mem_rdata, 32'd0);
   endtask

   // Start a transaction and pull reset during ACCESS.
   task automatic resetMidAccess();
      @(negedge i_clk);
      i_cpu_mem_valid = 1'b1;
      i_aip_sel       = 1'b1;
      i_cpu_mem_addr  = {28'd0, R_DATA, 2'b00};
      i_cpu_mem_wdata = 32'hCAFEF00D;
      i_cpu_mem_wen   = 1'b1;
      i_aip_enable    = 1'b1;
      @(posedge i_clk);
      modelEdge(1'b0);
      @(negedge i_clk);
      i_cpu_mem_valid = 1'b0;
      i_aip_int       = 1'b0;
      i_rst           = 1'b0;
      #1;
      modelReset();
      checkOutput("rst.ready", {31'd0, o_cpu_mem_ready}, 32'd0);
      checkOutput("rst.rdata", o_cpu_mem_rdata, 32'd0);
      checkOutput("rst.strobes", {29'd0, o_aip_read, o_aip_write, o_aip_start}, 32'd0);
      checkStatic("rst");
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      modelEdge(1'b0);
      #1;
      checkOutput("postrst.ready", {31'd0, o_cpu_mem_ready}, 32'd0);
   endtask

   initial begin
      i_rst           = 1'b0;
      i_cpu_mem_valid = 1'b0;
      i_cpu_mem_addr  = 32'd0;
      i_cpu_mem_wdata = 32'd0;
      i_cpu_mem_wen   = 1'b0;
      i_aip_sel       = 1'b0;
      i_aip_enable    = 1'b1;
      i_aip_dataOut   = 32'd0;
      i_aip_int       = 1'b0;
      modelReset();
      #2;
      checkOutput("reset.ready", {31'd0, o_cpu_mem_ready}, 32'd0);
      checkOutput("reset.rdata", o_cpu_mem_rdata, 32'd0);
      checkOutput("reset.strobes", {29'd0, o_aip_read, o_aip_write, o_aip_start}, 32'd0);
      checkStatic("reset");
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;

      // CONFIG write then read back.
      applyStimulus(R_CONFIG, 32'h0000001F, 1'b1, 1'b1, 32'd0, 1'b0);
      applyStimulus(R_CONFIG, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);
      // DATA write and DATA read.
      applyStimulus(R_DATA, 32'hDEADBEEF, 1'b1, 1'b1, 32'd0, 1'b0);
      applyStimulus(R_DATA, 32'd0, 1'b0, 1'b1, 32'h12345678, 1'b0);
      // START pulse, enable interrupt, AIP done pulse, read and clear STATUS.
      applyStimulus(R_START, 32'd1, 1'b1, 1'b1, 32'd0, 1'b0);
      applyStimulus(R_START, 32'd0, 1'b1, 1'b1, 32'd0, 1'b0);
      applyStimulus(R_STATUS, 32'd2, 1'b1, 1'b1, 32'd0, 1'b0);
      idleCycle(1'b1);
      idleCycle(1'b0);
      applyStimulus(R_STATUS, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);
      applyStimulus(R_STATUS, 32'd3, 1'b1, 1'b1, 32'd0, 1'b0);
      // Clear coinciding with a new rising edge leaves the interrupt pending.
      idleCycle(1'b0);
      applyStimulus(R_STATUS, 32'd3, 1'b1, 1'b1, 32'd0, 1'b1);
      // Core disabled: acknowledged, but no side effects and zero read data.
      applyStimulus(R_DATA, 32'h00000055, 1'b1, 1'b0, 32'd0, 1'b0);
      applyStimulus(R_CONFIG, 32'h00000003, 1'b1, 1'b0, 32'd0, 1'b0);
      applyStimulus(R_CONFIG, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
      // Reset during ACCESS, then a normal transaction afterwards.
      resetMidAccess();
      applyStimulus(R_CONFIG, 32'h0000000A, 1'b1, 1'b1, 32'd0, 1'b0);
      applyStimulus(R_CONFIG, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0);

      // Randomized transactions interleaved with random AIP interrupt activity.
      for (int i = 0; i < 60; i++) begin
         applyStimulus(2'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 4) != 0),
                       $urandom, 1'($urandom));
         if ($urandom_range(0, 1) == 1) idleCycle(1'($urandom));
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/native_aip.md
NATIVE_AIP -- requirements
Module: native_aip

Interface
REQ-001 SHALL have ports i_clk (in, 1, sole clock, rising edge) and i_rst (in, 1); one clock; reset is asynchronous and active-low.
REQ-002 SHALL have i_cpu_mem_valid (in, 1, CPU request valid) and i_cpu_mem_addr (in, 32, byte address; only bits [3:2] decoded).
REQ-003 SHALL have i_cpu_mem_wdata (in, 32, write data) and i_cpu_mem_wen (in, 1, 1 = write, 0 = read).
REQ-004 SHALL have o_cpu_mem_rdata (out, 32, read data) and o_cpu_mem_ready (out, 1, one-cycle acknowledge).
REQ-005 SHALL have o_cpu_irq (out, 1) and o_core_int (out, 1), both the interrupt request.
REQ-006 SHALL have i_aip_sel (in, 1, address hit) and i_aip_enable (in, 1, core enable).
REQ-007 SHALL have i_aip_dataOut (in, 32, AIP read data) and i_aip_int (in, 1, AIP done/interrupt, level).
REQ-008 SHALL have o_aip_dataIn (out, 32), o_aip_config (out, 5), o_aip_read (out, 1), o_aip_write (out, 1) and o_aip_start (out, 1).

Function
REQ-009 SHALL decode i_cpu_mem_addr[3:2] as follows: 0 DATA, 1 CONFIG, 2 START, 3 STATUS.
REQ-010 SHALL implement the FSM IDLE -> ACCESS -> ACK -> IDLE.
- IDLE leaves only when i_cpu_mem_valid && i_aip_sel.
- ACCESS and ACK each last exactly one cycle.
REQ-011 SHALL capture address, wdata and wen at the IDLE exit edge; input changes after that edge SHALL be ignored for that transaction.
REQ-012 SHALL drive o_cpu_mem_ready=1 only in ACK, so ready occurs 2 cycles after the request is sampled.
REQ-013 SHALL drive o_cpu_mem_rdata with the captured read value during ACK and 0 otherwise; writes return 0.
REQ-014 DATA write: o_aip_dataIn SHALL take wdata and hold it; o_aip_write SHALL be high for the ACCESS cycle only.
REQ-015 DATA read: o_aip_read SHALL be high for the ACCESS cycle only; i_aip_dataOut SHALL be sampled at the end of ACCESS.
REQ-016 CONFIG: a write SHALL load wdata[4:0] into o_aip_config (held); a read SHALL return {27'b0, config}.
REQ-017 START: a write with wdata[0]=1 SHALL pulse o_aip_start for the ACCESS cycle; wdata[0]=0 SHALL have no effect; a read SHALL return 0.
REQ-018 STATUS bits SHALL be:
- bit0 int_pending (sticky);
- bit1 irq_en (R/W);
- bit2 live i_aip_int.
REQ-019 A STATUS write SHALL load irq_en from wdata[1]; wdata[0]=1 SHALL clear int_pending.
REQ-020 int_pending SHALL set on a rising edge of i_aip_int; a set and a clear in the same cycle SHALL leave it set.
REQ-021 o_cpu_irq and o_core_int SHALL equal int_pending && irq_en (registered).
REQ-022 With i_aip_enable=0, a transaction SHALL still be acknowledged with the same latency, with:
- no read, write or start strobe;
- no register update;
- rdata 0.
REQ-023 A transaction in progress SHALL complete regardless of i_cpu_mem_valid or i_aip_sel changes.
REQ-024 At most one strobe among o_aip_read, o_aip_write and o_aip_start SHALL be high in any cycle.

Reset
REQ-025 While i_rst=0 the block SHALL asynchronously enter IDLE and clear:
- every output to 0;
- the config, data, int_pending and irq_en registers to 0.
REQ-026 A reset mid-transaction SHALL abort it with no acknowledge; after release the block SHALL accept a new request from IDLE.

Configuration
REQ-027 With macro NATIVE_AIP_IRQ_EN defined, REQ-018 to REQ-021 SHALL be implemented.
REQ-028 Without NATIVE_AIP_IRQ_EN:
- o_cpu_irq and o_core_int SHALL be tied 0;
- STATUS reads SHALL return {29'b0, i_aip_int, 2'b0};
- STATUS writes SHALL be ignored.

Verification
REQ-029 Write CONFIG=0x1F then read CONFIG -> o_aip_config=5'h1F; read returns 0x0000001F; ready occurs 2 cycles after valid.
REQ-030 Write DATA=0xDEADBEEF -> o_aip_dataIn=0xDEADBEEF; o_aip_write is a single-cycle pulse; ready follows 1 cycle later.
REQ-031 Drive i_aip_dataOut=0x12345678 and read DATA -> one o_aip_read pulse; rdata=0x12345678 on the ready cycle.
REQ-032 Write START=1, then pulse i_aip_int with irq_en=1:
- one o_aip_start pulse;
- o_cpu_irq=1, STATUS read=0x3;
- writing STATUS=0x3 clears o_cpu_irq.
REQ-033 i_aip_enable=0 with DATA write 0x55 -> ready after 2 cycles, no o_aip_write pulse, o_aip_dataIn unchanged.
REQ-034 Assert i_rst=0 during ACCESS -> all outputs 0 immediately, no ready; the next request completes normally.
